// File: rtl/tamagotchi_gfx_pkg.sv
// Shared graphics types and sprite geometry for the sprite reader.
// Holds sprite dimensions, the RGB565 pixel type and the streamer FSM states.
package tamagotchi_gfx_pkg;
    localparam int SPR_W     = 13;
    localparam int SPR_H     = 13;
    localparam int N_SPRITES = 7;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;
endpackage

// File: rtl/sprite_pixel_streamer_if.sv
// Pixel stream toward the display driver: valid/ready plus frame markers.
// master = pixel source (streamer), slave = pixel sink (LCD/SPI driver).
interface sprite_pixel_streamer_if;
    import tamagotchi_gfx_pkg::*;

    rgb565_t px_data;
    logic    px_valid;
    logic    px_ready;
    logic    px_first;
    logic    px_last;

    modport master (
        output px_data, px_valid, px_first, px_last,
        input  px_ready
    );

    modport slave (
        input  px_data, px_valid, px_first, px_last,
        output px_ready
    );
endinterface

// File: rtl/sprite_addr_gen.sv
// Raster walker: row/col with horizontal (sx) and vertical (sy) repeat counters.
// Ports: clk, rst (async low), clear, advance in; idx, sx_wrap, line_wrap, frame_end, first out.
module sprite_addr_gen
    import tamagotchi_gfx_pkg::*;
#(
    parameter int SCALE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] idx,
    output logic       sx_wrap,
    output logic       line_wrap,
    output logic       frame_end,
    output logic       first
);
    localparam logic [2:0] S_MAX   = 3'(SCALE - 1);
    localparam logic [3:0] COL_MAX = 4'(SPR_W - 1);
    localparam logic [3:0] ROW_MAX = 4'(SPR_H - 1);
    localparam logic [7:0] STEP    = 8'(SPR_W);

    logic [3:0] row, col;
    logic [2:0] sx, sy;
    logic [7:0] base;

    assign sx_wrap   = (sx == S_MAX);
    assign line_wrap = sx_wrap && (col == COL_MAX);
    assign frame_end = line_wrap && (sy == S_MAX) && (row == ROW_MAX);
    assign first     = (row == 4'd0) && (col == 4'd0) && (sx == 3'd0) && (sy == 3'd0);
    assign idx       = base + {4'd0, col};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row  <= '0;
            col  <= '0;
            sx   <= '0;
            sy   <= '0;
            base <= '0;
        end else if (clear || (advance && frame_end)) begin
            // returning to zero after the last beat keeps the index in range
            row  <= '0;
            col  <= '0;
            sx   <= '0;
            sy   <= '0;
            base <= '0;
        end else if (advance) begin
            if (!sx_wrap) begin
                sx <= sx + 3'd1;
            end else begin
                sx <= '0;
                if (col != COL_MAX) begin
                    col <= col + 4'd1;
                end else begin
                    col <= '0;
                    if (sy != S_MAX) begin
                        sy <= sy + 3'd1;
                    end else begin
                        sy   <= '0;
                        row  <= row + 4'd1;
                        base <= base + STEP;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/sprite_pixel_streamer.sv
// Walks one 13x13 RGB565 sprite from memory and streams it, optionally up-scaled.
// Ports: clk, rst (async low), start/sprite_sel in, busy/done out, mem_* to ROM, px stream.
module sprite_pixel_streamer
    import tamagotchi_gfx_pkg::*;
#(
    parameter int SCALE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sprite_sel,
    output logic       busy,
    output logic       done,
    output logic [2:0] mem_adress,
    output logic [7:0] mem_contador_pixel,
    input  rgb565_t    mem_pixel,
    sprite_pixel_streamer_if.master px
);
    localparam logic [2:0] SEL_MAX = 3'(N_SPRITES - 1);

    state_t  state, nxt;
    rgb565_t pix_q;
    logic    clear, advance, load, valid;
    logic    sx_wrap, line_wrap, frame_end, first;

    sprite_addr_gen #(.SCALE(SCALE)) u_addr (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .advance   (advance),
        .idx       (mem_contador_pixel),
        .sx_wrap   (sx_wrap),
        .line_wrap (line_wrap),
        .frame_end (frame_end),
        .first     (first)
    );

    always_comb begin
        nxt     = state;
        clear   = 1'b0;
        advance = 1'b0;
        load    = 1'b0;
        valid   = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clear = 1'b1;
                    nxt   = LOAD;
                end
            end
            LOAD: begin
                load = 1'b1;
                nxt  = SEND;
            end
            SEND: begin
                valid = 1'b1;
                if (px.px_ready) begin
                    advance = 1'b1;
                    // horizontal repeats reuse the held pixel with no bubble
                    if (frame_end)
                        nxt = DONE;
                    else if (sx_wrap)
                        nxt = LOAD;
                end
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            mem_adress <= '0;
            pix_q      <= '0;
        end else begin
            state <= nxt;
            if (clear) begin
                busy       <= 1'b1;
                mem_adress <= (sprite_sel <= SEL_MAX) ? sprite_sel : 3'd0;
            end
            if (state == DONE)
                busy <= 1'b0;
            if (load)
                pix_q <= mem_pixel;
        end
    end

    assign px.px_data  = pix_q;
    assign px.px_valid = valid;
    assign px.px_first = valid && first;
    assign px.px_last  = valid && frame_end;
endmodule
